// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, beq/bne branching, RUN/HANDLER exception controller with EPC/cause and eret.
// Optional misaligned-target trapping is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic [1:0]       PCSource,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [25:0]      IR_low26,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] PCvalue,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       exc_cause,
  output logic             in_handler,
  output logic             redirect
);

  localparam int unsigned HI_W = WIDTH - 28;

  typedef enum logic {S_RUN = 1'b0, S_HANDLER = 1'b1} state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  logic [WIDTH-1:0] r_epc, w_epc_nxt;
  logic [1:0]       r_cause, w_cause_nxt;
  logic             r_redirect, w_redirect_nxt;
  logic             r_in_handler;

  logic             w_taken, w_write, w_nonseq, w_misalign;
  logic [WIDTH-1:0] w_sel, w_tgt, w_tgt_load;
  logic [HI_W-1:0]  w_pc_hi;

  // State and output registers; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_RUN;
      r_pc         <= RESET_VEC;
      r_epc        <= '0;
      r_cause      <= CAUSE_NONE;
      r_redirect   <= 1'b0;
      r_in_handler <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_epc        <= w_epc_nxt;
      r_cause      <= w_cause_nxt;
      r_redirect   <= w_redirect_nxt;
      r_in_handler <= (w_state_nxt == S_HANDLER);
    end
  end

  // Candidate target, exception decision and next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_cause_nxt    = r_cause;
    w_redirect_nxt = 1'b0;

    w_pc_hi  = r_pc[WIDTH-1:28];
    w_taken  = PCWriteCond & (zero ^ branch_ne);
    w_write  = w_taken | PCWrite;
    w_nonseq = w_taken | (PCSource != 2'b00);

    case (PCSource)
      2'b00:   w_sel = result;
      2'b01:   w_sel = ALUOut;
      2'b10:   w_sel = {w_pc_hi, IR_low26, 2'b00};
      default: w_sel = reg_target;
    endcase
    w_tgt = w_taken ? ALUOut : w_sel;

`ifdef PC_MISALIGN_TRAP_EN
    w_misalign = w_write & (w_tgt[1:0] != 2'b00) & (r_state == S_RUN);
    w_tgt_load = (r_state == S_HANDLER) ? {w_tgt[WIDTH-1:2], 2'b00} : w_tgt;
`else
    w_misalign = 1'b0;
    w_tgt_load = w_tgt;
`endif

    case (r_state)
      S_RUN: begin
        if (exc_req || w_misalign) begin
          w_state_nxt    = S_HANDLER;
          w_pc_nxt       = EXC_VEC;
          w_epc_nxt      = r_pc;
          w_cause_nxt    = exc_req ? CAUSE_EXT : CAUSE_MIS;
          w_redirect_nxt = 1'b1;
        end else if (w_write) begin
          w_pc_nxt       = w_tgt_load;
          w_redirect_nxt = w_nonseq;
        end
      end
      default: begin
        // exc_req is masked here; eret beats any concurrent write.
        if (eret) begin
          w_state_nxt    = S_RUN;
          w_pc_nxt       = r_epc;
          w_cause_nxt    = CAUSE_NONE;
          w_redirect_nxt = 1'b1;
        end else if (w_write) begin
          w_pc_nxt       = w_tgt_load;
          w_redirect_nxt = w_nonseq;
        end
      end
    endcase
  end

  assign PCvalue    = r_pc;
  assign epc        = r_epc;
  assign exc_cause  = r_cause;
  assign in_handler = r_in_handler;
  assign redirect   = r_redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations plus randomized
// stimulus checked every cycle against a behavioural model. Honours PC_MISALIGN_TRAP_EN if defined.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, PCWrite, PCWriteCond, branch_ne, zero, exc_req, eret;
  logic [1:0]  PCSource;
  logic [31:0] result, ALUOut, reg_target;
  logic [25:0] IR_low26;
  logic [31:0] PCvalue, epc;
  logic [1:0]  exc_cause;
  logic        in_handler, redirect;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_h, m_redir;

  pc_unit dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .branch_ne(branch_ne), .zero(zero), .PCSource(PCSource), .result(result),
    .ALUOut(ALUOut), .reg_target(reg_target), .IR_low26(IR_low26),
    .exc_req(exc_req), .eret(eret), .PCvalue(PCvalue), .epc(epc),
    .exc_cause(exc_cause), .in_handler(in_handler), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b1; PCWrite = 1'b0; PCWriteCond = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    exc_req = 1'b0; eret = 1'b0; PCSource = 2'b00;
    result = '0; ALUOut = '0; reg_target = '0; IR_low26 = '0;
  endtask

  // Reference: applies the per-edge priority rules to the model state.
  task automatic model_edge();
    logic        taken, wr, mis;
    logic [31:0] target;
    if (!rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0; m_h = 1'b0; m_redir = 1'b0;
      return;
    end
    taken = PCWriteCond && (zero != branch_ne);
    wr    = taken || PCWrite;
    if (taken)                 target = ALUOut;
    else if (PCSource == 2'd0) target = result;
    else if (PCSource == 2'd1) target = ALUOut;
    else if (PCSource == 2'd2) target = (m_pc & 32'hF000_0000) + (32'(IR_low26) * 4);
    else                       target = reg_target;
    mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    mis = wr && (target % 4 != 0);
    if (m_h) target = target - (target % 4);
`endif
    if (!m_h && (exc_req || mis)) begin
      m_epc = m_pc; m_pc = 32'h180; m_cause = exc_req ? 2'd1 : 2'd2; m_h = 1'b1; m_redir = 1'b1;
    end else if (m_h && eret) begin
      m_pc = m_epc; m_cause = 2'd0; m_h = 1'b0; m_redir = 1'b1;
    end else if (wr) begin
      m_pc = target; m_redir = taken || (PCSource != 2'd0);
    end else begin
      m_redir = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("pc",         PCvalue,          m_pc);
    chk("epc",        epc,              m_epc);
    chk("cause",      32'(exc_cause),   32'(m_cause));
    chk("in_handler", 32'(in_handler),  32'(m_h));
    chk("redirect",   32'(redirect),    32'(m_redir));
  endtask

  // Apply current inputs for one edge, advance the model, compare after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    idle();
    @(negedge clk);

    // Reset with PCWrite asserted
    rst = 1'b0; PCWrite = 1'b1; result = 32'h44;
    step();
    chk("rst_pc", PCvalue, 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);

    // Sequential, then jump
    idle(); PCWrite = 1'b1; result = 32'h4; step();
    chk("seq_pc", PCvalue, 32'h4);
    chk("seq_redirect", 32'(redirect), 32'h0);
    result = 32'h1000_0004; step();
    PCSource = 2'b10; IR_low26 = 26'h40; step();
    chk("jump_pc", PCvalue, 32'h1000_0100);
    chk("jump_redirect", 32'(redirect), 32'h1);

    // Branch modes
    idle(); PCWrite = 1'b1; result = 32'h0; step();
    idle(); PCWriteCond = 1'b1; ALUOut = 32'h40; zero = 1'b1; step();
    chk("beq_taken", PCvalue, 32'h40);
    ALUOut = 32'h80; branch_ne = 1'b1; step();
    chk("bne_hold", PCvalue, 32'h40);
    zero = 1'b0; step();
    chk("bne_taken", PCvalue, 32'h80);

    // Exception round trip
    idle(); PCWrite = 1'b1; result = 32'h20; step();
    exc_req = 1'b1; result = 32'h24; step();
    chk("exc_pc", PCvalue, 32'h180);
    chk("exc_epc", epc, 32'h20);
    chk("exc_cause", 32'(exc_cause), 32'h1);
    chk("exc_inh", 32'(in_handler), 32'h1);
    result = 32'h184; step();
    chk("nest_epc", epc, 32'h20);
    idle(); eret = 1'b1; PCWrite = 1'b1; PCSource = 2'b01; ALUOut = 32'h300; step();
    chk("eret_pc", PCvalue, 32'h20);
    chk("eret_cause", 32'(exc_cause), 32'h0);
    chk("eret_inh", 32'(in_handler), 32'h0);

    // eret in RUN is ignored
    idle(); eret = 1'b1; PCWrite = 1'b1; result = 32'h8; step();
    chk("eret_run_pc", PCvalue, 32'h8);

    // Misaligned jr
    idle(); PCWrite = 1'b1; PCSource = 2'b11; reg_target = 32'h102; step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", PCvalue, 32'h180);
    chk("mis_epc", epc, 32'h8);
    chk("mis_cause", 32'(exc_cause), 32'h2);
    idle(); eret = 1'b1; step();
`else
    chk("mis_pc", PCvalue, 32'h102);
    idle(); PCWrite = 1'b1; result = 32'h8; step();
`endif
    chk("back_pc", PCvalue, 32'h8);

    // exc_req together with a misaligned target
    idle(); exc_req = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; reg_target = 32'h102; step();
    chk("both_cause", 32'(exc_cause), 32'h1);
    chk("both_epc", epc, 32'h8);

    // Reset coincident with eret in HANDLER
    idle(); rst = 1'b0; eret = 1'b1; step();
    chk("rst_eret_pc", PCvalue, 32'h0);
    chk("rst_eret_inh", 32'(in_handler), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      PCWrite     = ($urandom_range(0, 1) == 1);
      PCWriteCond = ($urandom_range(0, 3) == 0);
      branch_ne   = 1'($urandom);
      zero        = 1'($urandom);
      PCSource    = 2'($urandom);
      exc_req     = ($urandom_range(0, 9) == 0);
      eret        = ($urandom_range(0, 5) == 0);
      IR_low26    = 26'($urandom);
      result      = $urandom & 32'hFFFF_FFFC;
      ALUOut      = $urandom & 32'hFFFF_FFFC;
      reg_target  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) result     = result     | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) ALUOut     = ALUOut     | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) reg_target = reg_target | 32'($urandom_range(1, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle CPU datapath; the next generation of the PC register. Holds the PC, selects the next PC from sequential, branch, jump and register-jump sources, and adds `bne` support. Adds a two-state exception controller with an EPC/cause register pair and `eret` return, plus optional misaligned-target trapping. Sits between the control FSM/ALU and the instruction-memory address port.

## Interface
- `WIDTH`, 32: PC/data width; must be ≥ 32.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `EXC_VEC`, 32'h0000_0180: PC loaded on exception entry.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `PCWrite` in 1: unconditional PC write enable.
- `PCWriteCond` in 1: conditional (branch) write enable.
- `branch_ne` in 1: 0 = branch taken when `zero` = 1 (beq); 1 = branch taken when `zero` = 0 (bne).
- `zero` in 1: ALU zero flag.
- `PCSource` in 2: 00 `result`; 01 `ALUOut`; 10 jump; 11 `reg_target`.
- `result` in WIDTH: ALU combinational result (PC+4).
- `ALUOut` in WIDTH: registered ALU output (branch target).
- `reg_target` in WIDTH: register-file value (jr).
- `IR_low26` in 26: instruction index field.
- `exc_req` in 1: external exception/interrupt request, level.
- `eret` in 1: return-from-exception strobe from control.
- `PCvalue` out WIDTH: current PC.
- `epc` out WIDTH: exception PC.
- `exc_cause` out 2: 00 none, 01 external, 10 misaligned target.
- `in_handler` out 1: controller in HANDLER state.
- `redirect` out 1: registered; 1 for the cycle after any non-sequential load (branch, jump, source 01/11, exception, eret).

## Operation
- States: RUN, HANDLER.
- Candidate target `tgt`:
  - Branch taken (`PCWriteCond` & (`zero` ^ `branch_ne`)) → `ALUOut`.
  - Else if `PCWrite`: selected by `PCSource`. Jump = {`PCvalue`[WIDTH-1:28], `IR_low26`, 2'b00}, zero-extended into bits [27:0].
  - Else: hold.
- Per-edge priority, highest first:
  1. Reset: `PCvalue` = RESET_VEC, `epc` = 0, `exc_cause` = 00, state RUN, `redirect` = 0.
  2. Exception entry (RUN only): on `exc_req` = 1, or a misaligned-target trap. Effects: `PCvalue` ← EXC_VEC; `epc` ← current `PCvalue`; `exc_cause` ← 01 (external) or 10 (misaligned); state → HANDLER. If both exception sources are present in the same cycle, cause = 01.
  3. `eret` in HANDLER: `PCvalue` ← `epc`; `exc_cause` ← 00; state → RUN.
  4. Branch or write: `PCvalue` ← `tgt`.
  5. Hold.
- In HANDLER:
  - `exc_req` is masked: no nesting; `epc` and `exc_cause` are frozen.
  - A level `exc_req` still asserted after `eret` re-enters on the first RUN cycle.
- `eret` in RUN is ignored and treated as absent.
- `eret` together with a branch/write in HANDLER: `eret` wins.
- `in_handler` = (state == HANDLER), registered.
- All arithmetic is modulo 2^WIDTH. No adder inside the block; PC+4 comes from `result`.

## Timing
- Next-PC selection is combinational. `PCvalue`, `epc`, `exc_cause`, state and `redirect` are registered, with 1-cycle latency from inputs.
- `PCvalue` is never written outside a rising edge. There is no initial block; the value is undefined until the first reset edge.
- `rst` low mid-operation overrides everything on that edge, including a pending exception or `eret`.
- Exception entry takes one edge; `redirect` = 1 on the following cycle.
- `eret` return takes one edge.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - In RUN, a write whose `tgt`[1:0] ≠ 00 does not load `tgt`. It triggers exception entry with cause 10; `epc` = the `PCvalue` of the issuing instruction.
  - In HANDLER, misaligned targets are loaded with bits [1:0] forced to 00.
- Not defined:
  - `tgt` is loaded unmodified in all states.
  - Cause 10 is never produced.

## Test plan
- Reset: `rst` = 0 for one edge with `PCWrite` = 1 → `PCvalue` = 0, `epc` = 0, `exc_cause` = 00, `in_handler` = 0, `redirect` = 0.
- Sequential and jump:
  - `PCWrite` = 1, `PCSource` = 00, `result` = 0x4 → `PCvalue` = 0x4, `redirect` = 0 next cycle.
  - From `PCvalue` = 0x1000_0004, `PCSource` = 10, `IR_low26` = 0x000_0040 → `PCvalue` = 0x1000_0100, `redirect` = 1.
- Branch modes:
  - `PCWriteCond` = 1, `ALUOut` = 0x40, `zero` = 1, `branch_ne` = 0 → 0x40.
  - Same inputs with `branch_ne` = 1 → PC holds.
  - `zero` = 0, `branch_ne` = 1 → 0x40.
- Exception round trip:
  - At `PCvalue` = 0x20, `exc_req` = 1 with `PCWrite` = 1 → `PCvalue` = 0x180, `epc` = 0x20, `exc_cause` = 01, `in_handler` = 1.
  - A second `exc_req` in HANDLER → `epc` unchanged.
  - `eret` → `PCvalue` = 0x20, `exc_cause` = 00, `in_handler` = 0.
- Misaligned jr:
  - With `PC_MISALIGN_TRAP_EN`, at PC = 0x8, `PCSource` = 11, `reg_target` = 0x102 → `PCvalue` = 0x180, `epc` = 0x8, cause = 10.
  - Without the macro → `PCvalue` = 0x102.
- Collisions:
  - `exc_req` and misalign in the same cycle → cause 01.
  - `rst` = 0 coincident with `eret` in HANDLER → `PCvalue` = 0, state RUN.
